// File: rtl/mem_arb_if.sv
// Bundle of fetch, data-stage and byte-wide memory-port signals around mem_arb.
// slave = arbiter side, master = requester/memory side.
interface mem_arb_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_a;
  logic              if_ok;
  logic [31:0]       if_dt;

  logic              mm_req;
  logic              mm_wr;
  logic [1:0]        mm_len;
  logic [ADDR_W-1:0] mm_a;
  logic [31:0]       mm_wn;
  logic              mm_ok;
  logic [31:0]       mm_dt;

  logic [7:0]        rom_rn;
  logic [7:0]        rom_wn;
  logic [ADDR_W-1:0] rom_a;
  logic              rom_wr;

  logic              busy;

  modport slave (
    input  if_req, if_a, mm_req, mm_wr, mm_len, mm_a, mm_wn, rom_rn,
    output if_ok, if_dt, mm_ok, mm_dt, rom_wn, rom_a, rom_wr, busy
  );

  modport master (
    output if_req, if_a, mm_req, mm_wr, mm_len, mm_a, mm_wn, rom_rn,
    input  if_ok, if_dt, mm_ok, mm_dt, rom_wn, rom_a, rom_wr, busy
  );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: serialises fetch and data-stage transfers onto one byte-wide memory port.
// Define ARB_RR_EN for round-robin arbitration; otherwise mm has fixed priority.
//
// state | meaning
// IDLE  | sample requests, latch the winner's transfer
// XFER  | drive one byte address (and write byte) per cycle
// TAIL  | capture the last read byte, port idle
// DONE  | one-cycle ok pulse to the granted requester
module mem_arb #(
  parameter int ADDR_W = 32
) (
  input  logic     clk,
  input  logic     rst,
  mem_arb_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_TAIL,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_gnt_if;
  logic              r_wr;
  logic [2:0]        r_n;
  logic [2:0]        r_cnt;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_wdata;
  logic [31:0]       r_data;
  logic [31:0]       r_if_dt;
  logic [31:0]       r_mm_dt;

  logic              w_any_req;
  logic              w_gnt_if;
  logic [2:0]        w_mm_n;
  logic              w_last;
  logic [7:0]        w_wbyte;
  logic              w_cap_en;
  logic [1:0]        w_cap_idx;
  logic [31:0]       w_data_cap;

  logic              w_if_ok;
  logic              w_mm_ok;
  logic [ADDR_W-1:0] w_rom_a;
  logic              w_rom_wr;
  logic [7:0]        w_rom_wn;
  logic              w_busy;

  assign w_any_req = bus.if_req | bus.mm_req;

`ifdef ARB_RR_EN
  logic r_prio_mm;

  // A lone request always wins; the pointer only breaks ties.
  assign w_gnt_if = bus.if_req & (~bus.mm_req | ~r_prio_mm);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio_mm <= 1'b1;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_prio_mm <= w_gnt_if;
    end
  end
`else
  assign w_gnt_if = bus.if_req & ~bus.mm_req;
`endif

  always_comb begin
    case (bus.mm_len)
      2'd0:    w_mm_n = 3'd1;
      2'd1:    w_mm_n = 3'd2;
      default: w_mm_n = 3'd4;
    endcase
  end

  assign w_last = (r_cnt == (r_n - 3'd1));

  always_comb begin
    case (r_cnt[1:0])
      2'd0:    w_wbyte = r_wdata[7:0];
      2'd1:    w_wbyte = r_wdata[15:8];
      2'd2:    w_wbyte = r_wdata[23:16];
      default: w_wbyte = r_wdata[31:24];
    endcase
  end

  // Memory answers one cycle after the address, so the byte on rom_rn
  // belongs to the address driven with cnt-1.
  assign w_cap_en  = ((r_state == S_XFER) && (r_cnt != 3'd0) && !r_wr) ||
                     (r_state == S_TAIL);
  assign w_cap_idx = r_cnt[1:0] - 2'd1;

  always_comb begin
    w_data_cap = r_data;
    case (w_cap_idx)
      2'd0:    w_data_cap[7:0]   = bus.rom_rn;
      2'd1:    w_data_cap[15:8]  = bus.rom_rn;
      2'd2:    w_data_cap[23:16] = bus.rom_rn;
      default: w_data_cap[31:24] = bus.rom_rn;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_if_ok     = 1'b0;
    w_mm_ok     = 1'b0;
    w_rom_a     = '0;
    w_rom_wr    = 1'b0;
    w_rom_wn    = 8'h00;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_any_req) begin
          w_state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        w_rom_a  = r_base + ADDR_W'(r_cnt);
        w_rom_wr = r_wr;
        w_rom_wn = r_wr ? w_wbyte : 8'h00;
        if (w_last) begin
          w_state_nxt = r_wr ? S_DONE : S_TAIL;
        end
      end
      S_TAIL: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_if_ok     = r_gnt_if;
        w_mm_ok     = ~r_gnt_if;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt_if <= 1'b0;
      r_wr     <= 1'b0;
      r_n      <= 3'd0;
      r_cnt    <= 3'd0;
      r_base   <= '0;
      r_wdata  <= 32'h0;
      r_data   <= 32'h0;
      r_if_dt  <= 32'h0;
      r_mm_dt  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt_if <= w_gnt_if;
            r_base   <= w_gnt_if ? bus.if_a : bus.mm_a;
            r_n      <= w_gnt_if ? 3'd4 : w_mm_n;
            r_wr     <= ~w_gnt_if & bus.mm_wr;
            r_wdata  <= w_gnt_if ? 32'h0 : bus.mm_wn;
            r_cnt    <= 3'd0;
            r_data   <= 32'h0;
          end
        end
        S_XFER: begin
          r_cnt <= r_cnt + 3'd1;
          if (w_cap_en) begin
            r_data <= w_data_cap;
          end
        end
        S_TAIL: begin
          // Bytes beyond n were cleared at grant, so mm_dt comes out zero-extended.
          r_data <= w_data_cap;
          if (r_gnt_if) begin
            r_if_dt <= w_data_cap;
          end else begin
            r_mm_dt <= w_data_cap;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.if_ok  = w_if_ok;
  assign bus.mm_ok  = w_mm_ok;
  assign bus.if_dt  = r_if_dt;
  assign bus.mm_dt  = r_mm_dt;
  assign bus.rom_a  = w_rom_a;
  assign bus.rom_wr = w_rom_wr;
  assign bus.rom_wn = w_rom_wn;
  assign bus.busy   = w_busy;

  a_ok_excl: assert property (@(posedge clk) disable iff (rst) !(bus.if_ok && bus.mm_ok));

endmodule
